alu_issue_stage: RTL

//  Producer side of the ALU operand interface. Accepts 32-bit RV64I instructions over valid/ready, decodes
//  OP (0110011) and OP-IMM (0010011), and reads rs1/rs2 from the register file. It presents registered
//  {a, b, funct3, funct7, rd} to the ALU/execute stage over valid/ready. A 32-entry scoreboard stalls RAW hazards.

---
 rtl/alu_issue_if.sv | 35 +++
 rtl/alu_issue_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Issue-stage bundle: instruction intake, regfile read port, ALU operand output and writeback notify.
// The slave modport is the issue stage; the master modport is its environment.
interface alu_issue_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic            wb_valid;
    logic [4:0]      wb_rd;

    modport slave (
        input  in_valid, in_instr, rs1_data, rs2_data, out_ready, wb_valid, wb_rd,
        output in_ready, rs1_addr, rs2_addr, out_valid, out_a, out_b,
               out_funct3, out_funct7, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, rs1_data, rs2_data, out_ready, wb_valid, wb_rd,
        input  in_ready, rs1_addr, rs2_addr, out_valid, out_a, out_b,
               out_funct3, out_funct7, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV64I OP/OP-IMM issue stage: decodes, reads operands, and presents a one-entry registered ALU op.
// A 32-bit busy scoreboard stalls read-after-write hazards until the destination is written back.
module alu_issue_stage #(
    parameter int XLEN       = 64,
    parameter bit SCOREBOARD = 1'b1
) (
    input logic        clk,
    input logic        rst,
    alu_issue_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      shamt_hi;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_sext;

    logic            dec_legal;
    logic [XLEN-1:0] dec_b_raw;
    logic [6:0]      dec_f7_raw;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [2:0]      dec_f3;
    logic [6:0]      dec_f7;
    logic [4:0]      dec_rd;

    logic            slot_free;
    logic            hazard;
    logic            accept;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_a_q, out_a_d;
    logic [XLEN-1:0] out_b_q, out_b_d;
    logic [2:0]      out_f3_q, out_f3_d;
    logic [6:0]      out_f7_q, out_f7_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_ill_q, out_ill_d;
    logic [31:0]     busy_q, busy_d;

    assign opcode   = bus.in_instr[6:0];
    assign rd       = bus.in_instr[11:7];
    assign funct3   = bus.in_instr[14:12];
    assign rs1      = bus.in_instr[19:15];
    assign rs2      = bus.in_instr[24:20];
    assign funct7   = bus.in_instr[31:25];
    assign shamt_hi = bus.in_instr[31:26];
    assign imm_sext = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};

    assign bus.rs1_addr = rs1;
    assign bus.rs2_addr = rs2;

    always_comb begin
        dec_legal  = 1'b0;
        dec_b_raw  = '0;
        dec_f7_raw = F7_ZERO;
        case (opcode)
            OPC_OP: begin
                dec_b_raw  = bus.rs2_data;
                dec_f7_raw = funct7;
                dec_legal  = (funct7 == F7_ZERO) ||
                             ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec_b_raw = imm_sext;
                case (funct3)
                    3'b001: dec_legal = (shamt_hi == 6'b000000);
                    3'b101: begin
                        if (shamt_hi == 6'b000000) begin
                            dec_legal = 1'b1;
                        end else if (shamt_hi == 6'b010000) begin
                            dec_legal  = 1'b1;
                            dec_f7_raw = F7_ALT;
                        end
                    end
                    // immediate bits never reach funct7 here, so ADDI cannot alias SUB
                    default: dec_legal = 1'b1;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_a  = '0;
        dec_b  = '0;
        dec_f3 = '0;
        dec_f7 = '0;
        dec_rd = '0;
        if (dec_legal) begin
            dec_a  = bus.rs1_data;
            dec_b  = dec_b_raw;
            dec_f3 = funct3;
            dec_f7 = dec_f7_raw;
            dec_rd = rd;
        end
    end

    // Hazard sees busy bits before this cycle's writeback clear: no bypass.
    assign slot_free    = !out_valid_q || bus.out_ready;
    assign hazard       = SCOREBOARD && bus.in_valid &&
                          (busy_q[rs1] || ((opcode == OPC_OP) && busy_q[rs2]));
    assign bus.in_ready = slot_free && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_f3_d    = out_f3_q;
        out_f7_d    = out_f7_q;
        out_rd_d    = out_rd_q;
        out_ill_d   = out_ill_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = dec_a;
            out_b_d     = dec_b;
            out_f3_d    = dec_f3;
            out_f7_d    = dec_f7;
            out_rd_d    = dec_rd;
            out_ill_d   = !dec_legal;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (SCOREBOARD && accept && dec_legal && (dec_rd != 5'd0)) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_f3_q    <= '0;
            out_f7_q    <= '0;
            out_rd_q    <= '0;
            out_ill_q   <= 1'b0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_f3_q    <= out_f3_d;
            out_f7_q    <= out_f7_d;
            out_rd_q    <= out_rd_d;
            out_ill_q   <= out_ill_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_funct3  = out_f3_q;
    assign bus.out_funct7  = out_f7_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_illegal = out_ill_q;
endmodule
